clk_enable_divider: RTL and testbench

Parametrised multi-channel clock-enable generator running entirely on clk_50Mhz. It supersedes ripple-clocked divider chains. Each of NUM_CH channels has a runtime-programmable divisor and produces a one-cycle tick (clock enable) and a registered square-wave level. Divisor changes are glitch-free, and a sync input phase-aligns all channels.

---
 rtl/clk_enable_divider.sv | 83 ++++++++
 tb/tb_clk_enable_divider.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_enable_divider.sv
// Multi-channel clock-enable generator on clk_50Mhz: per-channel programmable divisor,
// one-cycle tick, registered square wave, shadowed glitch-free divisor updates and sync restart.
module clk_enable_divider #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 10000000,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50Mhz,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] div_pend
);

    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [CNT_W-1:0]  div_q  [NUM_CH];
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] wr_hit;
    logic [CNT_W-1:0]  div_clamped;
    logic              ch_valid;

    assign div_clamped = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;
    assign ch_valid    = ({1'b0, div_ch} < (CH_W + 1)'(NUM_CH));

    // A pending shadow lands at a period boundary (wrap or sync) or at once when idle.
    always_comb begin
        wrap   = '0;
        apply  = '0;
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]   = (cnt[i] == div_q[i] - CNT_W'(1));
            wr_hit[i] = div_wr && ch_valid && (div_ch == CH_W'(i));
            if (ch_en[i])
                apply[i] = div_pend[i] && (wrap[i] || sync);
            else
                apply[i] = div_pend[i];
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst_n) begin
                cnt[i]      <= '0;
                div_q[i]    <= CNT_W'(DEF_DIV);
                shadow[i]   <= CNT_W'(DEF_DIV);
                tick[i]     <= 1'b0;
                clk_out[i]  <= 1'b0;
                div_pend[i] <= 1'b0;
            end else begin
                if (ch_en[i]) begin
                    clk_out[i] <= (cnt[i] >= (div_q[i] >> 1));
                    tick[i]    <= wrap[i] && !sync;
                    if (sync || wrap[i])
                        cnt[i] <= '0;
                    else
                        cnt[i] <= cnt[i] + CNT_W'(1);
                end else begin
                    cnt[i]     <= '0;
                    tick[i]    <= 1'b0;
                    clk_out[i] <= 1'b0;
                end
                if (apply[i]) begin
                    div_q[i]    <= shadow[i];
                    div_pend[i] <= 1'b0;
                end
                // A write on the applying edge wins the pending flag for the next boundary.
                if (wr_hit[i]) begin
                    shadow[i]   <= div_clamped;
                    div_pend[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_divider.sv
// Bench for clk_enable_divider: per-cycle reference model on random and directed stimulus,
// a table of divisor/period/duty records, and hand-written corner sequences.
module tb_clk_enable_divider;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int DEF = 10;

    logic           clk_50Mhz = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] ch_en;
    logic           sync;
    logic           div_wr;
    logic [1:0]     div_ch;
    logic [CW-1:0]  div_val;
    logic [NCH-1:0] tick, clk_out, div_pend;
    logic [2:0]     tick3, clk_out3, div_pend3;

    int n_checks = 0;
    int n_err    = 0;

    clk_enable_divider #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF)) u_dut (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .ch_en(ch_en), .sync(sync),
        .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .tick(tick), .clk_out(clk_out), .div_pend(div_pend));

    clk_enable_divider #(.NUM_CH(3), .CNT_W(CW), .DEF_DIV(DEF)) u_dut3 (
        .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .ch_en(ch_en[2:0]), .sync(sync),
        .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .tick(tick3), .clk_out(clk_out3), .div_pend(div_pend3));

    always #10 clk_50Mhz = ~clk_50Mhz;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50Mhz);
        #1;
    endtask

    // Reference model: each channel tracks its position within the current period.
    int m_pos [NCH];
    int m_div [NCH];
    int m_sh  [NCH];
    bit m_pend[NCH];
    bit m_tick[NCH];
    bit m_clk [NCH];
    bit model_valid = 0;

    task automatic model_step();
        int nv;
        bit boundary;
        nv = (int'(div_val) < 2) ? 2 : int'(div_val);
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                m_pos[c] = 0; m_div[c] = DEF; m_sh[c] = DEF;
                m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
            end else begin
                if (ch_en[c]) begin
                    m_clk[c]  = (m_pos[c] >= m_div[c] / 2);
                    boundary  = sync || (m_pos[c] == m_div[c] - 1);
                    m_tick[c] = !sync && (m_pos[c] == m_div[c] - 1);
                    m_pos[c]  = boundary ? 0 : m_pos[c] + 1;
                end else begin
                    boundary = 1;
                    m_pos[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
                end
                if (boundary && m_pend[c]) begin
                    m_div[c] = m_sh[c];
                    m_pend[c] = 0;
                end
                if (div_wr && int'(div_ch) == c) begin
                    m_sh[c] = nv;
                    m_pend[c] = 1;
                end
            end
        end
        model_valid = 1;
    endtask

    initial begin
        logic [3*NCH-1:0] exp_v;
        forever begin
            @(negedge clk_50Mhz);
            if (model_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    exp_v[c]         = m_tick[c];
                    exp_v[NCH + c]   = m_clk[c];
                    exp_v[2*NCH + c] = m_pend[c];
                end
                chk("model {pend,clk_out,tick}", int'({div_pend, clk_out, tick}), int'(exp_v));
            end
            model_step();
        end
    end

    task automatic wait_tick(input int ch, output int n, output bit ok);
        n = 0; ok = 0;
        for (int k = 0; k < 600; k++) begin
            cyc();
            n++;
            if (tick[ch]) begin ok = 1; break; end
        end
    endtask

    // Period and clk_out low/high counts between two consecutive ticks.
    task automatic measure(input int ch, output int period, output int low, output int high);
        int n;
        bit ok;
        period = 0; low = 0; high = 0;
        wait_tick(ch, n, ok);
        if (!ok) return;
        for (int k = 0; k < 600; k++) begin
            cyc();
            period++;
            if (clk_out[ch]) high++; else low++;
            if (tick[ch]) break;
        end
    endtask

    task automatic set_div_idle(input int ch, input int val);
        ch_en[ch] = 1'b0;
        div_wr = 1'b1; div_ch = 2'(ch); div_val = CW'(val);
        cyc();
        div_wr = 1'b0;
        chk("pend set after idle write", int'(div_pend[ch]), 1);
        cyc();
        chk("pend cleared one cycle later", int'(div_pend[ch]), 0);
    endtask

    typedef struct {
        int ch;
        int val;
        int period;
        int low;
        int high;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int p, lo, hi, n, f0, f1;
        bit ok, t12;
        vecs[0] = '{1, 5, 5, 2, 3};
        vecs[1] = '{2, 0, 2, 1, 1};
        vecs[2] = '{3, 1, 2, 1, 1};
        vecs[3] = '{0, 7, 7, 3, 4};
        vecs[4] = '{2, 3, 3, 1, 2};
        vecs[5] = '{1, 16, 16, 8, 8};

        rst_n = 1'b0; ch_en = '1; sync = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
        repeat (3) cyc();
        chk("reset tick", int'(tick), 0);
        chk("reset clk_out", int'(clk_out), 0);
        chk("reset div_pend", int'(div_pend), 0);
        rst_n = 1'b1;

        measure(0, p, lo, hi);
        chk("default period", p, DEF);
        chk("default low", lo, 5);
        chk("default high", hi, 5);
        chk("default pend", int'(div_pend), 0);

        foreach (vecs[v]) begin
            set_div_idle(vecs[v].ch, vecs[v].val);
            ch_en[vecs[v].ch] = 1'b1;
            measure(vecs[v].ch, p, lo, hi);
            chk($sformatf("vec%0d period", v), p, vecs[v].period);
            chk($sformatf("vec%0d low", v), lo, vecs[v].low);
            chk($sformatf("vec%0d high", v), hi, vecs[v].high);
        end

        div_wr = 1'b1; div_ch = 2'd3; div_val = CW'(2);
        cyc();
        div_wr = 1'b0;
        chk("3-ch instance ignores ch3 write", int'(div_pend3), 0);
        chk("4-ch instance accepts ch3 write", int'(div_pend[3]), 1);

        set_div_idle(0, 10);
        ch_en[0] = 1'b1;
        wait_tick(0, n, ok);
        repeat (3) cyc();
        div_wr = 1'b1; div_ch = 2'd0; div_val = CW'(4);
        cyc();
        div_wr = 1'b0;
        chk("change pend held", int'(div_pend[0]), 1);
        n = 1;
        for (int k = 0; k < 20 && !tick[0]; k++) begin
            cyc();
            n++;
        end
        chk("tick after change at cnt=3", n, 7);
        chk("pend cleared at wrap", int'(div_pend[0]), 0);
        measure(0, p, lo, hi);
        chk("new period after change", p, 4);

        set_div_idle(0, 6);
        set_div_idle(1, 12);
        ch_en[0] = 1'b1;
        repeat ($urandom_range(1, 5)) cyc();
        ch_en[1] = 1'b1;
        repeat ($urandom_range(3, 20)) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("no tick on sync edge", int'(tick[1:0]), 0);
        f0 = 0; f1 = 0; t12 = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (tick[0] && f0 == 0) f0 = k;
            if (tick[1] && f1 == 0) f1 = k;
            if (k == 12) t12 = tick[0];
        end
        chk("sync ch0 first tick", f0, 6);
        chk("sync ch1 first tick", f1, 12);
        chk("sync ticks coincide", int'(t12), 1);

        wait_tick(0, n, ok);
        repeat (5) cyc();
        rst_n = 1'b0; div_wr = 1'b1; div_ch = 2'd0; div_val = CW'(3);
        cyc();
        rst_n = 1'b1; div_wr = 1'b0;
        chk("reset on wrap: no tick", int'(tick), 0);
        chk("reset on wrap: pend", int'(div_pend), 0);
        measure(0, p, lo, hi);
        chk("ch0 back to default", p, DEF);
        measure(1, p, lo, hi);
        chk("ch1 back to default", p, DEF);

        wait_tick(0, n, ok);
        repeat (9) cyc();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("sync on wrap: no tick", int'(tick[0]), 0);
        wait_tick(0, n, ok);
        chk("tick after sync on wrap", n, DEF);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            sync    = ($urandom_range(0, 39) == 0);
            div_wr  = ($urandom_range(0, 7) == 0);
            div_ch  = 2'($urandom_range(0, 3));
            div_val = CW'($urandom_range(0, 20));
            rst_n   = !($urandom_range(0, 499) == 0);
            cyc();
        end
        rst_n = 1'b1; sync = 1'b0; div_wr = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
